// File: rtl/yc_sync_driver.sv
// yc_sync_driver
//   Clocked host-side driver for a Morphle Logic ycfsm chain. Takes a word
//   over a valid/ready handshake and sends it LSB-first as return-to-empty
//   tokens (Vempty=0, V0=1, V1=2, 3 illegal) on tok_out. It synchronises the
//   asynchronous chain return tok_ret, accepts a symbol only after two equal
//   synchronised samples, and rebuilds the returned bits in res_out.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   data_in/valid   : word to send and its valid strobe
//   data_ready      : high only in IDLE
//   tok_out         : registered token driven into the chain
//   tok_ret         : chain output (asynchronous)
//   res_out         : returned word (partial updates visible mid-transaction)
//   res_valid       : one-cycle pulse when res_out holds a complete word
//   err, err_code   : sticky error; 1 = value timeout, 2 = empty timeout,
//                     3 = illegal code returned
//   err_clr         : leaves ERROR for IDLE; ignored in every other state
module yc_sync_driver #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [1:0]       tok_out,
    input  logic [1:0]       tok_ret,
    output logic [WIDTH-1:0] res_out,
    output logic             res_valid,
    output logic             err,
    output logic [1:0]       err_code,
    input  logic             err_clr
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] VEMPTY = 2'd0;
    localparam logic [1:0] V0     = 2'd1;
    localparam logic [1:0] V1     = 2'd2;
    localparam logic [1:0] VBAD   = 2'd3;

    typedef enum logic [2:0] {IDLE, WAIT_VAL, WAIT_EMPTY, DONE, ERROR} state_t;

    state_t                          state_q;
    logic [SYNC_STAGES-1:0][1:0]     sync_q;
    logic [1:0]                      prev_q;   // previous synchronised sample
    logic [WIDTH-1:0]                word_q;
    logic [IDXW-1:0]                 idx_q;
    logic [7:0]                      cnt_q;
    logic [1:0]                      tok_q;
    logic                            ready_q;
    logic [WIDTH-1:0]                res_q;
    logic                            rv_q;
    logic                            err_q;
    logic [1:0]                      code_q;

    logic [1:0]      s;
    logic            stable;
    logic            val_ok;
    logic            empty_ok;
    logic            bad_ok;
    logic            tmo_hit;
    logic            last_bit;
    logic [IDXW-1:0] idx_nxt;

    assign s        = sync_q[SYNC_STAGES-1];
    assign stable   = (s == prev_q);
    assign val_ok   = stable && (s == V0 || s == V1);
    assign empty_ok = stable && (s == VEMPTY);
    assign bad_ok   = stable && (s == VBAD);
    // The counter reaches TIMEOUT on the edge that moves to ERROR.
    assign tmo_hit  = (cnt_q == 8'(TIMEOUT - 1));
    assign last_bit = (idx_q == IDXW'(WIDTH - 1));
    assign idx_nxt  = idx_q + 1'b1;

    // Synchroniser plus stability register; free-running in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= VEMPTY;
        end else begin
            if (SYNC_STAGES > 1)
                sync_q <= {sync_q[SYNC_STAGES-2:0], tok_ret};
            else
                sync_q <= tok_ret;
            prev_q <= s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tok_q   <= VEMPTY;
            ready_q <= 1'b1;
            res_q   <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            rv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_valid && ready_q) begin
                        word_q  <= data_in;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        tok_q   <= data_in[0] ? V1 : V0;
                        ready_q <= 1'b0;
                        state_q <= WAIT_VAL;
                    end
                end
                WAIT_VAL: begin
                    if (val_ok) begin
                        res_q[idx_q] <= (s == V1);
                        tok_q        <= VEMPTY;
                        cnt_q        <= '0;
                        state_q      <= WAIT_EMPTY;
                    end else if (bad_ok) begin
                        tok_q   <= VEMPTY;
                        err_q   <= 1'b1;
                        code_q  <= 2'd3;
                        state_q <= ERROR;
                    end else if (tmo_hit) begin
                        cnt_q   <= cnt_q + 8'd1;
                        tok_q   <= VEMPTY;
                        err_q   <= 1'b1;
                        code_q  <= 2'd1;
                        state_q <= ERROR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WAIT_EMPTY: begin
                    if (empty_ok) begin
                        cnt_q <= '0;
                        if (last_bit) begin
                            rv_q    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_nxt;
                            tok_q   <= word_q[idx_nxt] ? V1 : V0;
                            state_q <= WAIT_VAL;
                        end
                    end else if (tmo_hit) begin
                        cnt_q   <= cnt_q + 8'd1;
                        err_q   <= 1'b1;
                        code_q  <= 2'd2;
                        state_q <= ERROR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                ERROR: begin
                    tok_q <= VEMPTY;
                    if (err_clr) begin
                        err_q   <= 1'b0;
                        code_q  <= 2'd0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tok_q   <= VEMPTY;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_ready = ready_q;
    assign tok_out    = tok_q;
    assign res_out    = res_q;
    assign res_valid  = rv_q;
    assign err        = err_q;
    assign err_code   = code_q;
endmodule

// File: tb/tb_yc_sync_driver.sv
// Directed bench for yc_sync_driver (defaults WIDTH=8, SYNC_STAGES=2,
// TIMEOUT=255). The chain is modelled per step: zero-delay identity,
// identity with a 3-cycle delay, a ycfsm matched at V0, or a hand-driven
// return.
module tb_yc_sync_driver;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [1:0] tok_out;
    logic [1:0] tok_ret;
    logic [7:0] res_out;
    logic       res_valid;
    logic       err;
    logic [1:0] err_code;
    logic       err_clr;

    int nvec  = 0;
    int nfail = 0;

    // 0 = identity, 1 = identity + 3 cycles, 2 = ycfsm match V0, 3 = manual
    int         mode = 0;
    logic [1:0] man  = 2'd0;
    logic [1:0] d1 = 2'd0, d2 = 2'd0, d3 = 2'd0, ycq = 2'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1  <= tok_out;
        d2  <= d1;
        d3  <= d2;
        ycq <= (tok_out == 2'd0) ? 2'd0 : 2'd1;
    end

    always_comb begin
        case (mode)
            0:       tok_ret = tok_out;
            1:       tok_ret = d3;
            2:       tok_ret = ycq;
            default: tok_ret = man;
        endcase
    end

    yc_sync_driver dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tok_out    (tok_out),
        .tok_ret    (tok_ret),
        .res_out    (res_out),
        .res_valid  (res_valid),
        .err        (err),
        .err_code   (err_code),
        .err_clr    (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one word; returns 1 ns into cycle 0.
    task automatic send(input logic [7:0] w);
        data_in    = w;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    // Zero-delay word with the documented cycle-accurate timing.
    task automatic latency_run(input logic [7:0] w);
        send(w);
        check("c0_tok", tok_out, w[0] ? 2'd2 : 2'd1);
        check("c0_ready", data_ready, 1'b0);
        for (int c = 1; c <= 65; c++) begin
            tick();
            if (c == 3)  check("c3_tok", tok_out, w[0] ? 2'd2 : 2'd1);
            if (c == 4)  check("c4_tok_empty", tok_out, 2'd0);
            if (c == 8)  check("c8_tok", tok_out, w[1] ? 2'd2 : 2'd1);
            if (c == 63) check("c63_rv", res_valid, 1'b0);
            if (c == 64) begin
                check("c64_rv", res_valid, 1'b1);
                check("c64_res", res_out, w);
                check("c64_ready", data_ready, 1'b0);
            end
            if (c == 65) begin
                check("c65_rv", res_valid, 1'b0);
                check("c65_ready", data_ready, 1'b1);
            end
        end
    endtask

    // Run until res_valid with a cycle budget, tracking tokens and rules.
    task automatic run_word(input logic [7:0] w, output logic [15:0] tokvec,
                            output int pulses, output int illegal, output int rdy_hi);
        logic [1:0] prev;
        int ntok;
        prev = 2'd0; ntok = 0; tokvec = '0; pulses = 0; illegal = 0; rdy_hi = 0;
        send(w);
        for (int c = 0; c < 400; c++) begin
            if (tok_out != prev) begin
                if (prev != 2'd0 && tok_out != 2'd0) illegal++;
                if (tok_out != 2'd0 && ntok < 8) begin
                    tokvec[2*ntok +: 2] = tok_out;
                    ntok++;
                end
                prev = tok_out;
            end
            if (data_ready) rdy_hi++;
            if (res_valid) begin
                pulses++;
                break;
            end
            tick();
        end
        tick();
        if (res_valid) pulses++;
    endtask

    logic [15:0] tv;
    int pl, il, rh;

    initial begin
        reset = 1'b1; data_in = '0; data_valid = 1'b0; err_clr = 1'b0;
        #12;
        check("rst_tok", tok_out, 2'd0);
        check("rst_ready", data_ready, 1'b1);
        check("rst_res", res_out, 8'h00);
        check("rst_rv", res_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 2'd0);
        reset = 1'b0;
        tick();

        // Zero-delay loopback, whole-word latency.
        mode = 0;
        latency_run(8'h3C);

        // ycfsm with match held at V0: every returned bit is 0.
        mode = 2;
        run_word(8'hFF, tv, pl, il, rh);
        check("yc_res", res_out, 8'h00);
        check("yc_err", err, 1'b0);
        check("yc_pulse", pl, 1);

        // Identity + 3-cycle delay loopback.
        mode = 1;
        tick();
        run_word(8'hA5, tv, pl, il, rh);
        check("lb_tokens", tv, 16'h9966);
        check("lb_res", res_out, 8'hA5);
        check("lb_pulse", pl, 1);
        check("lb_v0v1", il, 0);
        check("lb_ready_low", rh, 0);

        // One-cycle glitch to V1, then stable V0: bit 0 captured as 0.
        mode = 3; man = 2'd0;
        tick(); tick(); tick();
        send(8'h00);
        man = 2'd2;
        tick();
        man = 2'd0;
        for (int i = 0; i < 5; i++) tick();
        check("gl_tok_held", tok_out, 2'd1);
        man = 2'd1;
        for (int i = 0; i < 6; i++) tick();
        check("gl_tok_empty", tok_out, 2'd0);
        check("gl_bit0", res_out[0], 1'b0);
        check("gl_err", err, 1'b0);
        reset = 1'b1; man = 2'd0;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();

        // Return stuck at Vempty: value timeout.
        send(8'h01);
        for (int i = 0; i < 254; i++) tick();
        check("to_c254_err", err, 1'b0);
        tick();
        check("to_err", err, 1'b1);
        check("to_code", err_code, 2'd1);
        check("to_tok", tok_out, 2'd0);
        check("to_ready", data_ready, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clr_ready", data_ready, 1'b1);
        check("to_clr_err", err, 1'b0);
        check("to_clr_code", err_code, 2'd0);

        // Illegal code 3 held stable.
        send(8'h02);
        man = 2'd3;
        for (int i = 0; i < 6; i++) tick();
        check("bad_err", err, 1'b1);
        check("bad_code", err_code, 2'd3);
        check("bad_tok", tok_out, 2'd0);
        data_in = 8'h55; data_valid = 1'b1;
        tick(); tick(); tick();
        check("bad_ready", data_ready, 1'b0);
        check("bad_still_err", err, 1'b1);
        data_valid = 1'b0; man = 2'd0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("bad_clr_ready", data_ready, 1'b1);
        check("bad_clr_code", err_code, 2'd0);

        // Asynchronous reset mid-transaction, then a clean word.
        mode = 0;
        tick(); tick(); tick();
        send(8'h96);
        for (int i = 0; i < 20; i++) tick();
        check("mid_busy", data_ready, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_tok", tok_out, 2'd0);
        check("mid_rst_ready", data_ready, 1'b1);
        check("mid_rst_res", res_out, 8'h00);
        tick();
        #2 reset = 1'b0;
        tick(); tick(); tick();
        latency_run(8'h96);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
